oneshot_scheduler: RTL and testbench

//  Multi-channel one-shot timer bank. Each channel times a request in

---
 rtl/oneshot_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_oneshot_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/oneshot_scheduler.sv
// Multi-channel one-shot microsecond timer bank with a shared 1 us prescaler
// and one round-robin restoring divider that reports the remaining fraction.
module oneshot_scheduler #(
  parameter int CHANNELS = 4,
  parameter int CLK_FREQ = 50_000_000,
  parameter int USEC_W   = 24
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS*USEC_W-1:0]   usec,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          done,
  output logic [CHANNELS*8-1:0]        incomplete
);

  // state   | meaning
  // S_IDLE  | pick next busy channel after rr_q
  // S_LOAD  | latch remain*255 and dur of the picked channel
  // S_DIV   | one restoring-divide step per cycle
  // S_STORE | publish quotient unless aborted, advance rr_q

  localparam int P  = CLK_FREQ / 1_000_000;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW = USEC_W + 8;
  localparam int BW = $clog2(NW);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_STORE} state_t;

  state_t state_q, state_d;

  logic [PW-1:0]     pre_cnt;
  logic              tick;

  logic [USEC_W-1:0] dur_q    [CHANNELS];
  logic [USEC_W-1:0] remain_q [CHANNELS];
  logic [7:0]        inc_q    [CHANNELS];
  logic [CHANNELS-1:0] busy_q, done_q, expire;

  logic [CW-1:0]     ch_q, rr_q, pick;
  logic              found;
  int                idx;
  logic [NW-1:0]     quo_q, rem_ext, prod;
  logic [USEC_W-1:0] rem_q, den_q, rem_next;
  logic [USEC_W:0]   shifted;
  logic              ge;
  logic [BW-1:0]     bit_cnt;
  logic              abort_q;
  logic              store_en;

  // Free-running prescaler; its phase is never realigned to a start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)   pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == PW'(P - 1));

  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      expire[i] = tick && busy_q[i] && !start[i] && (remain_q[i] == USEC_W'(1));
  end

  assign store_en = (state_q == S_STORE) && !abort_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      busy_q <= '0;
      done_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        dur_q[i]    <= '0;
        remain_q[i] <= '0;
        inc_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        done_q[i] <= 1'b0;
        if (start[i]) begin
          if (usec[i*USEC_W +: USEC_W] != '0) begin
            dur_q[i]    <= usec[i*USEC_W +: USEC_W];
            remain_q[i] <= usec[i*USEC_W +: USEC_W];
            busy_q[i]   <= 1'b1;
            inc_q[i]    <= 8'hFF;
          end else begin
            busy_q[i]   <= 1'b0;
            inc_q[i]    <= 8'h00;
            done_q[i]   <= 1'b1;
          end
        end else begin
          if (tick && busy_q[i]) remain_q[i] <= remain_q[i] - 1'b1;
          if (expire[i]) begin
            busy_q[i] <= 1'b0;
            inc_q[i]  <= 8'h00;
            done_q[i] <= 1'b1;
          end else if (store_en && ch_q == CW'(i)) begin
            inc_q[i]  <= quo_q[7:0];
          end
        end
      end
    end
  end

  // Circular search starting one past the last served channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(rr_q) + k) % CHANNELS;
      if (!found && busy_q[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  assign rem_ext  = NW'(remain_q[ch_q]);
  assign prod     = (rem_ext << 8) - rem_ext;
  assign shifted  = {rem_q, quo_q[NW-1]};
  assign ge       = (shifted >= {1'b0, den_q});
  assign rem_next = ge ? USEC_W'(shifted - {1'b0, den_q}) : shifted[USEC_W-1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_LOAD;
      S_LOAD:  state_d = S_DIV;
      S_DIV:   if (bit_cnt == '0) state_d = S_STORE;
      S_STORE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ch_q    <= '0;
      rr_q    <= CW'(CHANNELS - 1);
      quo_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      bit_cnt <= '0;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (found) ch_q <= pick;
        S_LOAD: begin
          quo_q   <= prod;
          den_q   <= dur_q[ch_q];
          rem_q   <= '0;
          bit_cnt <= BW'(NW - 1);
          // a re-arm or expiry on this very edge would make the loaded value stale
          abort_q <= start[ch_q] | expire[ch_q];
        end
        S_DIV: begin
          quo_q   <= {quo_q[NW-2:0], ge};
          rem_q   <= rem_next;
          bit_cnt <= bit_cnt - 1'b1;
          if (start[ch_q] || expire[ch_q]) abort_q <= 1'b1;
        end
        S_STORE: rr_q <= ch_q;
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_inc
    assign incomplete[g*8 +: 8] = inc_q[g];
  end

endmodule

// File: tb/tb_oneshot_scheduler.sv
// Scoreboard bench for oneshot_scheduler: done events are predicted at start
// time and matched by a monitor; fraction values are hand-computed for P=4.
module tb_oneshot_scheduler;
  localparam int CH = 4;
  localparam int UW = 24;
  localparam int CF = 4_000_000;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [CH-1:0]      start;
  logic [CH*UW-1:0]   usec;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      done;
  logic [CH*8-1:0]    incomplete;

  oneshot_scheduler #(.CHANNELS(CH), .CLK_FREQ(CF), .USEC_W(UW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .usec(usec),
    .busy(busy), .done(done), .incomplete(incomplete)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {int ch; int t0; int lo; int hi;} exp_t;
  exp_t sb[$];
  exp_t e_mon;

  int total = 0;
  int bad   = 0;
  int s;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int inc(input int i);
    return int'(incomplete[i*8 +: 8]);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic go_to(input int e);
    while (cyc < e) step(1);
  endtask

  task automatic reset3();
    sys_rst = 1'b1;
    step(3);
    sys_rst = 1'b0;
  endtask

  // Drive a one-cycle start; a re-arm replaces the channel's pending prediction.
  task automatic arm(input int ch, input int u, input int lo, input int hi, input bit expect_done);
    int t0;
    t0 = cyc + 1;
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].ch == ch) sb.delete(k);
    if (expect_done) sb.push_back('{ch, t0, lo, hi});
    start[ch] = 1'b1;
    usec[ch*UW +: UW] = UW'(u);
    step(1);
    start[ch] = 1'b0;
  endtask

  int            prev_inc [CH];
  logic [CH-1:0] start_prev = '0;
  logic          rst_prev = 1'b1;
  int            cur;

  always @(negedge sys_clk) begin
    for (int i = 0; i < CH; i++) begin
      if (done[i] === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got done on ch%0d at cycle %0d, required none", i, cyc);
        end else begin
          e_mon = sb.pop_front();
          if (e_mon.ch != i || cyc - e_mon.t0 < e_mon.lo || cyc - e_mon.t0 > e_mon.hi) begin
            bad++;
            $display("FAIL done_event: got ch%0d latency %0d, required ch%0d latency %0d..%0d",
                     i, cyc - e_mon.t0, e_mon.ch, e_mon.lo, e_mon.hi);
          end
        end
      end
      cur = inc(i);
      if (cur != prev_inc[i] && !rst_prev && !start_prev[i]) begin
        total++;
        if (cur > prev_inc[i]) begin
          bad++;
          $display("FAIL non_increasing ch%0d: got %0d after %0d", i, cur, prev_inc[i]);
        end
      end
      prev_inc[i] = cur;
    end
    start_prev = start;
    rst_prev   = sys_rst;
  end

  initial begin
    sys_rst = 1'b1;
    start   = '0;
    usec    = '0;
    step(3);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_incomplete", int'(incomplete), 0);
    sys_rst = 1'b0;

    // reset in the middle of a division
    arm(0, 100, 0, 0, 1'b0);
    step(10);
    check("t1_busy_pre", int'(busy[0]), 1);
    reset3();
    check("t1_busy", int'(busy), 0);
    check("t1_incomplete", int'(incomplete), 0);
    step(5);
    check("t1_done_quiet", int'(done), 0);

    // single channel, 100 us
    reset3();
    s = cyc + 1;
    arm(0, 100, 397, 400, 1'b1);
    check("t2_busy", int'(busy[0]), 1);
    check("t2_inc_start", inc(0), 255);
    go_to(s + 35);  check("t2_inc_s35", inc(0), 255);
    go_to(s + 69);  check("t2_inc_s69", inc(0), 255);
    go_to(s + 70);  check("t2_inc_s70", inc(0), 232);
    go_to(s + 105); check("t2_inc_s105", inc(0), 209);
    go_to(s + 210); check("t2_inc_s210", inc(0), 142);
    go_to(s + 245); check("t2_inc_s245", inc(0), 119);
    check("t2_others", int'(incomplete[31:8]), 0);
    go_to(s + 401);
    check("t2_done_seen", sb.size(), 0);
    check("t2_busy_end", int'(busy[0]), 0);
    check("t2_inc_end", inc(0), 0);

    // zero duration, also as a re-arm of a running channel
    arm(2, 50, 197, 200, 1'b1);
    check("t3_inc_armed", inc(2), 255);
    step(5);
    arm(2, 0, 0, 0, 1'b1);
    check("t3_busy", int'(busy[2]), 0);
    check("t3_inc", inc(2), 0);
    step(2);
    check("t3_done_seen", sb.size(), 0);

    // restart on ch1 during its own division, on a tick edge
    reset3();
    s = cyc + 1;
    arm(1, 100, 397, 400, 1'b1);
    go_to(s + 105); check("t4_inc_s105", inc(1), 209);
    go_to(s + 118);
    arm(1, 100, 397, 400, 1'b1);
    check("t4_inc_restart", inc(1), 255);
    go_to(s + 141); check("t4_inc_discard", inc(1), 255);
    go_to(s + 175); check("t4_inc_s175", inc(1), 242);
    go_to(s + 520);
    check("t4_done_seen", sb.size(), 0);
    check("t4_busy_end", int'(busy[1]), 0);

    // re-arm coinciding with a tick does not lose a microsecond
    reset3();
    s = cyc + 1;
    arm(3, 10, 37, 40, 1'b1);
    go_to(s + 6);
    arm(3, 10, 40, 40, 1'b1);
    check("t6_busy", int'(busy[3]), 1);
    go_to(s + 48);
    check("t6_done_seen", sb.size(), 0);

    // all channels together
    reset3();
    s = cyc + 1;
    for (int c = 0; c < CH; c++) sb.push_back('{c, s, (40*(c+1)-1)*4 + 1, 40*(c+1)*4});
    usec  = {24'd160, 24'd120, 24'd80, 24'd40};
    start = 4'hF;
    step(1);
    start = '0;
    check("t5_busy", int'(busy), 15);
    check("t5_inc_start", int'(incomplete), 32'hFFFF_FFFF);
    go_to(s + 69);  check("t5_inc1_s69", inc(1), 255);
    go_to(s + 70);  check("t5_inc1_s70", inc(1), 226);
    go_to(s + 104); check("t5_inc2_s104", inc(2), 255);
    go_to(s + 105); check("t5_inc2_s105", inc(2), 216);
    go_to(s + 140); check("t5_inc3_s140", inc(3), 213);
    go_to(s + 160); check("t5_inc0_s160", inc(0), 0);
    check("t5_busy_s160", int'(busy), 14);
    go_to(s + 176); check("t5_inc0_abort", inc(0), 0);
    go_to(s + 210); check("t5_inc1_s210", inc(1), 114);
    go_to(s + 245); check("t5_inc2_s245", inc(2), 142);
    go_to(s + 280); check("t5_inc3_s280", inc(3), 157);
    go_to(s + 642);
    check("t5_done_seen", sb.size(), 0);
    check("t5_busy_end", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
